perf_counter_bank: RTL and testbench

PERF_COUNTER_BANK -- requirements
Module: perf_counter_bank

---
 rtl/perf_counter_bank.sv | 122 ++++++++++++
 tb/tb_perf_counter_bank.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/perf_counter_bank.sv
// rtl/perf_counter_bank.sv - cycle, instruction and event counter bank with a one-cycle read port
// Counter index 0 counts cycles, 1 counts retired instructions, 2.. count evt channels.
module perf_counter_bank #(
  parameter int NUM_EVT  = 4,
  parameter int CNT_W    = 32,
  parameter int SAT_MODE = 0,
  localparam int NCNT    = NUM_EVT + 2,
  localparam int SEL_W   = $clog2(NUM_EVT + 2)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               clear,
  input  logic               inst_commit,
  input  logic [NUM_EVT-1:0] evt,
  input  logic               halt,
  input  logic               rd_req,
  input  logic [SEL_W-1:0]   rd_sel,
  output logic               rd_valid,
  output logic [CNT_W-1:0]   rd_data,
  output logic               rd_err,
  output logic [NCNT-1:0]    ovf,
  output logic               done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_HALTED
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt     [NCNT];
  logic [CNT_W-1:0] cnt_nxt [NCNT];
  logic [NCNT-1:0]  inc;
  logic [NCNT-1:0]  at_max;
  logic [CNT_W-1:0] rd_mux;
  logic             rd_hit;

  // Only RUN advances counters; the cycle counter's strobe is tied high.
  assign inc = (state == S_RUN) ? {evt, inst_commit, 1'b1} : '0;

  always_comb begin
    at_max = '0;
    rd_mux = '0;
    rd_hit = 1'b0;
    for (int i = 0; i < NCNT; i++) begin
      at_max[i] = &cnt[i];
      if (at_max[i] && (SAT_MODE != 0)) begin
        cnt_nxt[i] = cnt[i];
      end else begin
        cnt_nxt[i] = cnt[i] + CNT_W'(1);
      end
      if (rd_sel == SEL_W'(i)) begin
        rd_mux = cnt[i];
        rd_hit = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= S_IDLE;
      done     <= 1'b0;
      ovf      <= '0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
      rd_err   <= 1'b0;
      for (int i = 0; i < NCNT; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      // Reads sample pre-edge counter values, so a read alongside clear sees the old count.
      rd_valid <= rd_req;
      if (rd_req) begin
        rd_data <= rd_mux;
        rd_err  <= ~rd_hit;
      end else begin
        rd_err  <= 1'b0;
      end

      if (clear) begin
        state <= S_IDLE;
        done  <= 1'b0;
        ovf   <= '0;
        for (int i = 0; i < NCNT; i++) begin
          cnt[i] <= '0;
        end
      end else begin
        for (int i = 0; i < NCNT; i++) begin
          if (inc[i]) begin
            cnt[i] <= cnt_nxt[i];
            if (at_max[i]) begin
              ovf[i] <= 1'b1;
            end
          end
        end
        case (state)
          S_IDLE: begin
            if (en) begin
              state <= S_RUN;
            end
          end
          S_RUN: begin
            if (halt) begin
              state <= S_HALTED;
              done  <= 1'b1;
            end
          end
          S_HALTED: begin
            state <= S_HALTED;
          end
          default: begin
            state <= S_IDLE;
            done  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_perf_counter_bank.sv
// tb/tb_perf_counter_bank.sv - scoreboard bench for perf_counter_bank, wrap and saturate instances
module tb_perf_counter_bank;

  localparam int     NE   = 4;
  localparam int     CW   = 8;
  localparam int     NC   = NE + 2;
  localparam int     SW   = 3;
  localparam longint MAXV = (longint'(1) << CW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          en = 1'b0;
  logic          clear = 1'b0;
  logic          inst_commit = 1'b0;
  logic          halt = 1'b0;
  logic          rd_req = 1'b0;
  logic [NE-1:0] evt = '0;
  logic [SW-1:0] rd_sel = '0;

  logic          rd_valid_w, rd_err_w, done_w;
  logic [CW-1:0] rd_data_w;
  logic [NC-1:0] ovf_w;
  logic          rd_valid_s, rd_err_s, done_s;
  logic [CW-1:0] rd_data_s;
  logic [NC-1:0] ovf_s;

  perf_counter_bank #(.NUM_EVT(NE), .CNT_W(CW), .SAT_MODE(0)) u_wrap (
    .clk(clk), .rst(rst), .en(en), .clear(clear), .inst_commit(inst_commit),
    .evt(evt), .halt(halt), .rd_req(rd_req), .rd_sel(rd_sel),
    .rd_valid(rd_valid_w), .rd_data(rd_data_w), .rd_err(rd_err_w),
    .ovf(ovf_w), .done(done_w)
  );

  perf_counter_bank #(.NUM_EVT(NE), .CNT_W(CW), .SAT_MODE(1)) u_sat (
    .clk(clk), .rst(rst), .en(en), .clear(clear), .inst_commit(inst_commit),
    .evt(evt), .halt(halt), .rd_req(rd_req), .rd_sel(rd_sel),
    .rd_valid(rd_valid_s), .rd_data(rd_data_s), .rd_err(rd_err_s),
    .ovf(ovf_s), .done(done_s)
  );

  always #5 clk = ~clk;

  typedef struct {
    longint dw;
    longint ds;
    bit     err;
  } rd_exp_t;

  typedef struct {
    bit            done;
    bit            rv;
    logic [NC-1:0] ovf;
    longint        dw;
    longint        ds;
  } st_exp_t;

  rd_exp_t rd_q[$];
  st_exp_t st_q[$];

  // Reference model: true event totals, unbounded; each mode is a view of that total.
  longint cnt_m [NC];
  int     st_m;
  longint last_w;
  longint last_s;

  int n_checks = 0;
  int n_fail   = 0;

  function automatic longint view_w(longint c);
    return c % (MAXV + 1);
  endfunction

  function automatic longint view_s(longint c);
    return (c > MAXV) ? MAXV : c;
  endfunction

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    rd_exp_t r;
    st_exp_t s;
    if (!rst) begin
      for (int i = 0; i < NC; i++) cnt_m[i] = 0;
      st_m   = 0;
      last_w = 0;
      last_s = 0;
    end else begin
      if (rd_req) begin
        if (int'(rd_sel) < NC) begin
          r.dw  = view_w(cnt_m[rd_sel]);
          r.ds  = view_s(cnt_m[rd_sel]);
          r.err = 1'b0;
        end else begin
          r.dw  = 0;
          r.ds  = 0;
          r.err = 1'b1;
        end
        rd_q.push_back(r);
        last_w = r.dw;
        last_s = r.ds;
      end
      if (clear) begin
        for (int i = 0; i < NC; i++) cnt_m[i] = 0;
        st_m = 0;
      end else if (st_m == 0) begin
        if (en) st_m = 1;
      end else if (st_m == 1) begin
        cnt_m[0] += 1;
        cnt_m[1] += longint'(inst_commit);
        for (int k = 0; k < NE; k++) cnt_m[k+2] += longint'(evt[k]);
        if (halt) st_m = 2;
      end
    end
    s.done = (st_m == 2);
    s.rv   = rst && rd_req;
    for (int i = 0; i < NC; i++) s.ovf[i] = (cnt_m[i] > MAXV);
    s.dw = last_w;
    s.ds = last_s;
    st_q.push_back(s);
    @(negedge clk);
  endtask

  st_exp_t mon_s;
  rd_exp_t mon_r;

  always @(posedge clk) begin
    #1;
    if (st_q.size() > 0) begin
      mon_s = st_q.pop_front();
      chk("done_wrap", longint'(done_w), longint'(mon_s.done));
      chk("done_sat", longint'(done_s), longint'(mon_s.done));
      chk("ovf_wrap", longint'(ovf_w), longint'(mon_s.ovf));
      chk("ovf_sat", longint'(ovf_s), longint'(mon_s.ovf));
      chk("rd_valid_wrap", longint'(rd_valid_w), longint'(mon_s.rv));
      chk("rd_valid_sat", longint'(rd_valid_s), longint'(mon_s.rv));
      chk("rd_data_hold_wrap", longint'(rd_data_w), mon_s.dw);
      chk("rd_data_hold_sat", longint'(rd_data_s), mon_s.ds);
    end
    if (rd_valid_w || rd_valid_s) begin
      if (rd_q.size() == 0) begin
        chk("spurious_rd_valid", 1, 0);
      end else begin
        mon_r = rd_q.pop_front();
        chk("rd_data_wrap", longint'(rd_data_w), mon_r.dw);
        chk("rd_data_sat", longint'(rd_data_s), mon_r.ds);
        chk("rd_err_wrap", longint'(rd_err_w), longint'(mon_r.err));
        chk("rd_err_sat", longint'(rd_err_s), longint'(mon_r.err));
      end
    end
  end

  task automatic quiet();
    rst = 1'b1; en = 1'b0; clear = 1'b0; inst_commit = 1'b0;
    halt = 1'b0; rd_req = 1'b0; evt = '0; rd_sel = '0;
  endtask

  initial begin
    // Reset with a read pending: it must be dropped.
    rst = 1'b0; rd_req = 1'b1;
    repeat (3) step();
    quiet(); step();

    // Basic counting: 10 RUN cycles, 6 commits, 3 evt[0].
    en = 1'b1; step(); en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      inst_commit = (i < 6);
      evt[0]      = (i < 3);
      step();
    end
    quiet();
    rd_req = 1'b1;
    for (int sel = 0; sel < 3; sel++) begin
      rd_sel = SW'(sel);
      step();
    end
    quiet();

    // Overflow: evt[1] for 257 RUN cycles.
    clear = 1'b1; step(); clear = 1'b0;
    en = 1'b1; step(); en = 1'b0;
    evt[1] = 1'b1;
    repeat (257) step();
    quiet();
    rd_req = 1'b1; rd_sel = 3; step();
    quiet();

    // Halt together with a commit at RUN cycle 20, then ignored inputs.
    clear = 1'b1; step(); clear = 1'b0;
    en = 1'b1; step(); en = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      inst_commit = (i == 20) ? 1'b1 : 1'($urandom_range(0, 1));
      halt        = (i == 20);
      step();
    end
    for (int i = 0; i < 5; i++) begin
      evt = (i % 2 == 0) ? '1 : '0;
      inst_commit = 1'($urandom_range(0, 1));
      en = 1'b1;
      halt = 1'($urandom_range(0, 1));
      step();
    end
    quiet();
    rd_req = 1'b1; rd_sel = 0; step();
    rd_sel = 1; step();
    quiet();

    // Read alongside clear returns the old count, next read returns 0.
    rd_req = 1'b1; rd_sel = 0; clear = 1'b1; step();
    clear = 1'b0; step();
    quiet(); step();

    // Out-of-range selects, then reset mid-RUN with a read in flight.
    rd_req = 1'b1; rd_sel = 7; step();
    rd_sel = 6; step();
    quiet();
    en = 1'b1; step(); en = 1'b0;
    repeat (15) begin
      evt = NE'($urandom);
      inst_commit = 1'($urandom_range(0, 1));
      step();
    end
    rst = 1'b0; rd_req = 1'b1; rd_sel = 0; step();
    rst = 1'b1;
    for (int sel = 0; sel < NC; sel++) begin
      rd_sel = SW'(sel);
      step();
    end
    quiet();

    // Random traffic.
    repeat (600) begin
      rst         = ($urandom_range(0, 99) != 0);
      clear       = ($urandom_range(0, 49) == 0);
      en          = ($urandom_range(0, 3) == 0);
      halt        = ($urandom_range(0, 59) == 0);
      inst_commit = 1'($urandom_range(0, 1));
      evt         = NE'($urandom);
      rd_req      = 1'($urandom_range(0, 1));
      rd_sel      = SW'($urandom);
      step();
    end
    quiet();
    step();
    step();
    repeat (2) @(posedge clk);
    #2;
    chk("rd_queue_drained", longint'(rd_q.size()), 0);
    chk("st_queue_drained", longint'(st_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
